// File: rtl/cog_loader.sv
// Launch-time loader: copies LONGS longs from hub memory into cog RAM starting
// at CA_BASE, one req/ack hub read followed by one cog RAM write per long.
//
// state | meaning
// IDLE  | waiting for start; all strobes low
// FETCH | hub_req high at base+cnt until hub_ack; hub_q captured into dreg
// WRITE | dreg written to cog RAM at CA_BASE+cnt; cnt advances
// DONE  | one-cycle completion pulse, then back to IDLE
module cog_loader #(
  parameter int LONGS   = 496,
  parameter int CA_BASE = 0,
  parameter int HW      = 14
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  input  logic [HW-1:0] ptr,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          hub_req,
  output logic [HW-1:0] hub_a,
  input  logic          hub_ack,
  input  logic [31:0]   hub_q,
  output logic          ram_ena,
  output logic          ram_w,
  output logic [8:0]    ram_a,
  output logic [31:0]   ram_d
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  localparam logic [9:0] LAST = 10'(LONGS - 1);
  localparam logic [8:0] CA   = 9'(CA_BASE);

  state_t        state, state_nx;
  logic [HW-1:0] base;
  logic [HW-1:0] hub_a_r;
  logic [9:0]    cnt;
  logic [31:0]   dreg;
  logic [8:0]    ram_a_r;

  always_ff @(posedge clk) begin
    if (res) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start && !abort) state_nx = FETCH;
      FETCH: begin
        if (abort)        state_nx = IDLE;
        else if (hub_ack) state_nx = WRITE;
      end
      WRITE: begin
        if (abort)            state_nx = IDLE;
        else if (cnt == LAST) state_nx = DONE;
        else                  state_nx = FETCH;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Addresses are registered one transition ahead so the buses come straight
  // from flops and simply hold their last value while idle.
  always_ff @(posedge clk) begin
    if (res) begin
      base    <= '0;
      cnt     <= '0;
      dreg    <= '0;
      hub_a_r <= '0;
      ram_a_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            base    <= ptr;
            cnt     <= '0;
            hub_a_r <= ptr;
          end
        end
        FETCH: begin
          if (hub_ack && !abort) begin
            dreg    <= hub_q;
            ram_a_r <= CA + cnt[8:0];
          end
        end
        WRITE: begin
          if (!abort) begin
            cnt     <= cnt + 10'd1;
            hub_a_r <= base + HW'(cnt + 10'd1);
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes are killed combinationally by abort, and by res so that no write
  // lands in the reset cycle.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    hub_req = 1'b0;
    ram_ena = 1'b0;
    ram_w   = 1'b0;
    case (state)
      FETCH: begin
        busy    = 1'b1;
        hub_req = !abort && !res;
      end
      WRITE: begin
        busy    = 1'b1;
        ram_ena = !abort && !res;
        ram_w   = !abort && !res;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign hub_a = hub_a_r;
  assign ram_a = ram_a_r;
  assign ram_d = dreg;

endmodule
